// File: rtl/snax_simbacore_csr_pkg.sv
// rtl/snax_simbacore_csr_pkg.sv - address map, word type and mode constants for the SimbaCore CSR manager
package snax_simbacore_csr_pkg;

  localparam int unsigned DefRegRWCount   = 6;
  localparam int unsigned DefRegROCount   = 2;
  localparam int unsigned DefRegDataWidth = 32;

  localparam int unsigned StartIdx = DefRegRWCount - 1;
  localparam int unsigned RoBase   = DefRegRWCount;

  typedef logic [DefRegDataWidth-1:0] reg_word_t;

  // Operating modes written into config register 0
  localparam reg_word_t ModeIdle = reg_word_t'(0);
  localparam reg_word_t ModeGemm = reg_word_t'(1);
  localparam reg_word_t ModeSimd = reg_word_t'(2);

  function automatic int unsigned start_index(input int unsigned rw_count);
    return rw_count - 1;
  endfunction

  function automatic int unsigned ro_base(input int unsigned rw_count);
    return rw_count;
  endfunction

endpackage

// File: rtl/snax_simbacore_csr_manager.sv
// rtl/snax_simbacore_csr_manager.sv - core CSR front end with shadow config and start-triggered launch handshake
module snax_simbacore_csr_manager
  import snax_simbacore_csr_pkg::*;
#(
  parameter int unsigned RegRWCount   = DefRegRWCount,
  parameter int unsigned RegROCount   = DefRegROCount,
  parameter int unsigned RegDataWidth = DefRegDataWidth,
  parameter int unsigned RegAddrWidth = 32
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [RegAddrWidth-1:0]                csr_req_addr_i,
  input  logic [RegDataWidth-1:0]                csr_req_data_i,
  input  logic                                   csr_req_write_i,
  input  logic                                   csr_req_valid_i,
  output logic                                   csr_req_ready_o,
  output logic [RegDataWidth-1:0]                csr_rsp_data_o,
  output logic                                   csr_rsp_valid_o,
  input  logic                                   csr_rsp_ready_i,
  output logic [RegRWCount-1:0][RegDataWidth-1:0] csr_reg_set_o,
  output logic                                   csr_reg_set_valid_o,
  input  logic                                   csr_reg_set_ready_i,
  input  logic [RegROCount-1:0][RegDataWidth-1:0] csr_reg_ro_set_i
);

  localparam int unsigned StartAt = start_index(RegRWCount);
  localparam int unsigned RoAt    = ro_base(RegRWCount);
  localparam logic [RegAddrWidth-1:0] StartAddr = RegAddrWidth'(StartAt);

  logic [RegRWCount-2:0][RegDataWidth-1:0] shadow_q;
  logic [RegRWCount-1:0][RegDataWidth-1:0] launch_q;
  logic                                    pending_q;
  logic                                    rsp_valid_q;
  logic [RegDataWidth-1:0]                 rsp_data_q;
  logic [RegDataWidth-1:0]                 rd_data;

  logic is_start, req_fire, wr_fire, rd_fire, start_fire;

  assign is_start = csr_req_write_i && (csr_req_addr_i == StartAddr);

  // A second start may only enter once the current launch is leaving this cycle
  assign csr_req_ready_o = !(rsp_valid_q && !csr_rsp_ready_i)
                         && !(is_start && pending_q && !csr_reg_set_ready_i);

  assign req_fire   = csr_req_valid_i && csr_req_ready_o;
  assign wr_fire    = req_fire && csr_req_write_i;
  assign rd_fire    = req_fire && !csr_req_write_i;
  assign start_fire = wr_fire && is_start;

  // Full-width address compares so high address bits never alias onto a register
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < RegRWCount - 1; i++) begin
      if (csr_req_addr_i == RegAddrWidth'(i)) rd_data = shadow_q[i];
    end
    if (csr_req_addr_i == StartAddr) rd_data = {{(RegDataWidth-1){1'b0}}, pending_q};
    for (int unsigned k = 0; k < RegROCount; k++) begin
      if (csr_req_addr_i == RegAddrWidth'(RoAt + k)) rd_data = csr_reg_ro_set_i[k];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
    end else if (wr_fire) begin
      for (int unsigned i = 0; i < RegRWCount - 1; i++) begin
        if (csr_req_addr_i == RegAddrWidth'(i)) shadow_q[i] <= csr_req_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      launch_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      if (pending_q && csr_reg_set_ready_i) pending_q <= 1'b0;
      if (start_fire) begin
        launch_q  <= {csr_req_data_i, shadow_q};
        pending_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else if (rd_fire) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= rd_data;
    end else if (csr_rsp_ready_i) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign csr_rsp_valid_o     = rsp_valid_q;
  assign csr_rsp_data_o      = rsp_data_q;
  assign csr_reg_set_valid_o = pending_q;
  assign csr_reg_set_o       = launch_q;

endmodule

// File: tb/tb_snax_simbacore_csr_manager.sv
// tb/tb_snax_simbacore_csr_manager.sv - self-checking bench for the SimbaCore CSR manager
module tb_snax_simbacore_csr_manager;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic [31:0]      req_addr = '0;
  logic [31:0]      req_data = '0;
  logic             req_write = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [31:0]      rsp_data;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [5:0][31:0] set_o;
  logic             set_valid;
  logic             set_ready = 1'b0;
  logic [1:0][31:0] ro_set = '0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  snax_simbacore_csr_manager dut (
    .clk_i               (clk),
    .rst_ni              (rst_ni),
    .csr_req_addr_i      (req_addr),
    .csr_req_data_i      (req_data),
    .csr_req_write_i     (req_write),
    .csr_req_valid_i     (req_valid),
    .csr_req_ready_o     (req_ready),
    .csr_rsp_data_o      (rsp_data),
    .csr_rsp_valid_o     (rsp_valid),
    .csr_rsp_ready_i     (rsp_ready),
    .csr_reg_set_o       (set_o),
    .csr_reg_set_valid_o (set_valid),
    .csr_reg_set_ready_i (set_ready),
    .csr_reg_ro_set_i    (ro_set)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: six config slots as plain arrays, a pending bit and one response slot
  logic [31:0] m_shadow [5];
  logic [31:0] m_launch [6];
  logic        m_pending;
  logic        m_rsp_valid;
  logic [31:0] m_rsp_data;

  function automatic logic model_ready();
    logic start_wr;
    start_wr = req_write && (req_addr == 32'd5);
    return !(m_rsp_valid && !rsp_ready) && !(start_wr && m_pending && !set_ready);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a < 32'd5) return m_shadow[a[2:0]];
    if (a == 32'd5) return {31'd0, m_pending};
    if (a == 32'd6) return ro_set[0];
    if (a == 32'd7) return ro_set[1];
    return 32'd0;
  endfunction

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 5; i++) m_shadow[i] <= '0;
      for (int i = 0; i < 6; i++) m_launch[i] <= '0;
      m_pending   <= 1'b0;
      m_rsp_valid <= 1'b0;
      m_rsp_data  <= '0;
    end else begin
      if (m_pending && set_ready) m_pending <= 1'b0;
      if (rsp_ready) m_rsp_valid <= 1'b0;
      if (req_valid && model_ready()) begin
        if (req_write) begin
          if (req_addr < 32'd5) m_shadow[req_addr[2:0]] <= req_data;
          if (req_addr == 32'd5) begin
            for (int i = 0; i < 5; i++) m_launch[i] <= m_shadow[i];
            m_launch[5] <= req_data;
            m_pending   <= 1'b1;
          end
        end else begin
          m_rsp_valid <= 1'b1;
          m_rsp_data  <= model_read(req_addr);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_ni) begin
      check("cmp_req_ready", {31'd0, req_ready}, {31'd0, model_ready()});
      check("cmp_set_valid", {31'd0, set_valid}, {31'd0, m_pending});
      if (m_pending)
        for (int i = 0; i < 6; i++) check($sformatf("cmp_set_o[%0d]", i), set_o[i], m_launch[i]);
      check("cmp_rsp_valid", {31'd0, rsp_valid}, {31'd0, m_rsp_valid});
      if (m_rsp_valid) check("cmp_rsp_data", rsp_data, m_rsp_data);
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic done;
    done = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; req_addr = a; req_data = d;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (req_ready) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("req_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    issue(1'b0, a, 32'd0);
    @(negedge clk);
    check({name, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    check(name, rsp_data, exp);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_set_valid", {31'd0, set_valid}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_set_o5", set_o[5], 32'd0);
    rst_ni = 1'b1; rsp_ready = 1'b1; set_ready = 1'b1;

    // Basic launch with the accelerator immediately ready
    issue(1'b1, 32'd0, 32'd1);
    issue(1'b1, 32'd1, 32'd16);
    issue(1'b1, 32'd2, 32'd64);
    issue(1'b1, 32'd3, 32'd4);
    issue(1'b1, 32'd4, 32'd128);
    issue(1'b1, 32'd5, 32'd1);
    @(negedge clk);
    check("launch_valid", {31'd0, set_valid}, 32'd1);
    check("launch_r0", set_o[0], 32'd1);
    check("launch_r1", set_o[1], 32'd16);
    check("launch_r2", set_o[2], 32'd64);
    check("launch_r3", set_o[3], 32'd4);
    check("launch_r4", set_o[4], 32'd128);
    check("launch_start", set_o[5], 32'd1);
    @(negedge clk);
    check("launch_one_cycle", {31'd0, set_valid}, 32'd0);

    // Accelerator stalls: config write must not disturb the launched values
    @(posedge clk); #1 set_ready = 1'b0;
    issue(1'b1, 32'd5, 32'd2);
    repeat (5) @(posedge clk);
    issue(1'b1, 32'd1, 32'd99);
    @(negedge clk);
    check("stall_r1_held", set_o[1], 32'd16);
    check("stall_valid", {31'd0, set_valid}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd5; req_data = 32'd3;
    repeat (3) begin
      @(negedge clk);
      check("start_stalled", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk); #1 set_ready = 1'b1;
    @(negedge clk);
    check("start_on_handshake", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    check("relaunch_valid", {31'd0, set_valid}, 32'd1);
    check("relaunch_r1", set_o[1], 32'd99);
    check("relaunch_start", set_o[5], 32'd3);
    @(negedge clk);
    check("relaunch_done", {31'd0, set_valid}, 32'd0);

    // Read response held while the core is not ready
    @(posedge clk); #1 ro_set[0] = 32'd1; ro_set[1] = 32'hABCD; rsp_ready = 1'b0;
    issue(1'b0, 32'd6, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd2;
    repeat (3) begin
      @(negedge clk);
      check("rsp_held_data", rsp_data, 32'd1);
      check("rsp_blocks_req", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_release_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    check("rd_r2_after_hold", rsp_data, 32'd64);

    // Pending flag, unmapped space, aliasing and dropped RO writes
    @(posedge clk); #1 set_ready = 1'b0;
    issue(1'b1, 32'd5, 32'd7);
    rd(32'd5, 32'd1, "rd_start_pending");
    rd(32'd100, 32'd0, "rd_unmapped");
    rd(32'h8000_0001, 32'd0, "rd_no_alias");
    issue(1'b1, 32'd6, 32'd55);
    rd(32'd6, 32'd1, "rd_ro0_after_write");
    rd(32'd7, 32'hABCD, "rd_ro1");

    // Asynchronous reset in the middle of a launch
    @(posedge clk); #3 rst_ni = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, set_valid}, 32'd0);
    check("async_rst_rsp", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1 rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) rd(32'(i), 32'd0, $sformatf("post_rst_r%0d", i));
    rd(32'd5, 32'd0, "post_rst_start");
    check("post_rst_set_valid", {31'd0, set_valid}, 32'd0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
